pack_fifo_credit: RTL
=====================

PACK_FIFO_CREDIT -- requirements
Module: pack_fifo_credit

Interface
REQ-001 SHALL have parameter W, default 16: word width in bits.
REQ-002 SHALL have parameter N, default 16: lanes per write/read bus; power of two, >=2.
REQ-003 SHALL have parameter DEPTH, default 256: storage in words; power of two, >=2*N.
REQ-004 SHALL have a single clock; reset is synchronous and active-high.
REQ-005 Ports (name, direction, width, meaning); CW = clog2(N+1), LW = clog2(DEPTH)+1:
 - clk  in  1  clock, all logic on rising edge
 - reset_p  in  1  synchronous active-high reset
 - data_i  in  N*W  write words, lane k at bits [k*W +: W], lane 0 first
 - wr_size_i  in  CW  number of words to write, 0 = no write, max N
 - rd_size_i  in  CW  number of words to pop, 0 = no pop, max N
 - data_o  out  N*W  head words, lane k = k-th oldest word
 - rd_avail_o  out  CW  number of valid lanes on data_o = min(level, N)
 - level_o  out  LW  words stored
 - free_o  out  LW  DEPTH - level_o
 - credit_o  out  CW  words released by the previous cycle's pop
 - full  out  1  free_o < N
 - empty  out  1  level_o == 0
 - wr_err  out  1  write rejected last cycle
 - rd_err  out  1  pop truncated last cycle

Function
REQ-006 Storage SHALL be a DEPTH-word circular buffer with LW-bit wr_ptr/rd_ptr; addresses wrap modulo DEPTH; level = wr_ptr - rd_ptr.
REQ-007 A write with wr_size_i = S > 0 SHALL be accepted only if S <= free_o at that edge; whole packet, never partial.
REQ-008 On acceptance, lanes 0..S-1 SHALL go to addresses wr_ptr..wr_ptr+S-1 (mod DEPTH), wrapping across the DEPTH boundary within one cycle; wr_ptr += S.
REQ-009 A rejected write SHALL store nothing and leave wr_ptr unchanged; wr_err = 1 for exactly the following cycle.
REQ-010 wr_size_i > N SHALL be treated as rejected (wr_err).
REQ-011 data_o lanes 0..rd_avail_o-1 SHALL be combinational reads at rd_ptr..rd_ptr+rd_avail_o-1 (mod DEPTH); lanes >= rd_avail_o SHALL be 0.
REQ-012 A pop with rd_size_i = R SHALL remove G = min(R, rd_avail_o) words; rd_ptr += G.
REQ-013 If R > rd_avail_o, rd_err = 1 for the following cycle (also for R > N).
REQ-014 credit_o SHALL equal G of the previous cycle (1-cycle latency), else 0; the sum of credit_o over time equals words popped.
REQ-015 Words written at edge t SHALL be visible on data_o/rd_avail_o after edge t (write-to-read latency 1); a same-cycle pop SHALL NOT return them.
REQ-016 Simultaneous write and pop SHALL both take effect: level' = level + S_acc - G; acceptance uses free_o before the pop (no same-cycle credit reuse).
REQ-017 level_o, free_o, full, empty SHALL be derived from registered pointers and be consistent every cycle.
REQ-018 level_o SHALL never exceed DEPTH, and rd_ptr SHALL never pass wr_ptr.
REQ-019 At level == DEPTH, every write with S > 0 SHALL be rejected; at level == 0, data_o = 0 and rd_avail_o = 0.

Reset
REQ-020 While reset_p = 1 at an edge: wr_ptr = rd_ptr = 0, credit_o = 0, wr_err = rd_err = 0; hence level_o = 0, free_o = DEPTH, empty = 1, full = 0, data_o = 0.
REQ-021 Reset SHALL override a write/pop in the same cycle; memory contents need not be cleared.
REQ-022 Reset mid-operation SHALL discard all stored words; credit_o SHALL NOT report the discarded words.

Verification (W=16, N=16, DEPTH=256)
REQ-023 After reset: write S=3 words 0x0A,0x0B,0x0C -> next cycle rd_avail_o=3, lanes 0..2 = 0A,0B,0C, lanes 3..15 = 0; pop R=2 -> credit_o=2 next cycle, data_o lane 0 = 0C.
REQ-024 Write 16 packets of S=16 -> level_o=256, full=1; a further S=1 write -> wr_err=1, level_o unchanged at 256.
REQ-025 Wrap: wr_ptr=250, write S=10 -> words at addresses 250..255,0..3; pop them all -> data_o order preserved across the wrap.
REQ-026 Level 5, pop R=8 -> G=5, rd_err=1, credit_o=5, empty=1.
REQ-027 Simultaneous: level 250, write S=8 with pop R=16 -> write rejected (free 6 < 8), G=16, level_o=234.
REQ-028 Reset asserted at level 100 together with write S=4 -> level_o=0, credit_o=0, empty=1 next cycle.

Source files
------------

// File: rtl/pack_fifo_credit.sv
// Packet-wide circular FIFO: writes and pops up to N words per cycle, reports
// the previous cycle's pop count as credit, flags rejected writes and short pops.
module pack_fifo_credit #(
  parameter int W     = 16,
  parameter int N     = 16,
  parameter int DEPTH = 256,
  localparam int CW   = $clog2(N + 1),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_p,
  input  logic [N*W-1:0]  data_i,
  input  logic [CW-1:0]   wr_size_i,
  input  logic [CW-1:0]   rd_size_i,
  output logic [N*W-1:0]  data_o,
  output logic [CW-1:0]   rd_avail_o,
  output logic [LW-1:0]   level_o,
  output logic [LW-1:0]   free_o,
  output logic [CW-1:0]   credit_o,
  output logic            full,
  output logic            empty,
  output logic            wr_err,
  output logic            rd_err
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, free;
  logic [CW-1:0] rd_avail, pop_cnt;
  logic          wr_ok, wr_bad, rd_short;

  // Acceptance uses the pre-pop free count, so a same-cycle pop never frees room.
  always_comb begin
    level    = wr_ptr - rd_ptr;
    free     = LW'(DEPTH) - level;
    rd_avail = (level >= LW'(N)) ? CW'(N) : level[CW-1:0];
    wr_ok    = (wr_size_i != '0) && (wr_size_i <= CW'(N)) && (LW'(wr_size_i) <= free);
    wr_bad   = (wr_size_i != '0) && !wr_ok;
    rd_short = rd_size_i > rd_avail;
    pop_cnt  = rd_short ? rd_avail : rd_size_i;
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N; k++) begin
      if (!reset_p && wr_ok && (CW'(k) < wr_size_i))
        mem[AW'(wr_ptr + LW'(k))] <= data_i[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      credit_o <= '0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + (wr_ok ? LW'(wr_size_i) : '0);
      rd_ptr   <= rd_ptr + LW'(pop_cnt);
      credit_o <= pop_cnt;
      wr_err   <= wr_bad;
      rd_err   <= rd_short;
    end
  end

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (CW'(k) < rd_avail)
        data_o[k*W +: W] = mem[AW'(rd_ptr + LW'(k))];
    end
  end

  assign rd_avail_o = rd_avail;
  assign level_o    = level;
  assign free_o     = free;
  assign full       = free < LW'(N);
  assign empty      = (level == '0);

endmodule
